// File: rtl/camera_pkg.sv
// Shared types and defaults for the camera array controller.
package camera_pkg;

    // Pixel rows read out per frame (one nre line per row).
    localparam int unsigned SIZE     = 2;
    // Exposure time register width and limits, in clock cycles.
    localparam int unsigned EXP_SIZE = 5;
    localparam int unsigned EXP_MIN  = 2;
    localparam int unsigned EXP_MAX  = 30;

    // Frame sequencer states; the fourth encoding is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPOSE = 2'd1,
        READ   = 2'd2
    } cam_state_t;

    // Front-end control lines, kept together so they can be registered as one word.
    typedef struct packed {
        logic erase;
        logic expose;
        logic nre1;
        logic nre2;
        logic adc;
    } cam_out_t;

    // Moore decode of the front-end lines for a given state and readout cycle.
    // Readout cycle bit 1 selects the row, bit 0 is the ADC strobe phase.
    function automatic cam_out_t decode_outputs(input cam_state_t st, input logic [1:0] cyc);
        cam_out_t o;
        o.erase  = 1'b1;
        o.expose = 1'b0;
        o.nre1   = 1'b1;
        o.nre2   = 1'b1;
        o.adc    = 1'b0;
        case (st)
            IDLE: begin
                o.erase = 1'b1;
            end
            EXPOSE: begin
                o.erase  = 1'b0;
                o.expose = 1'b1;
            end
            READ: begin
                o.erase = 1'b0;
                o.nre1  = cyc[1];
                o.nre2  = ~cyc[1];
                o.adc   = cyc[0];
            end
            default: begin
                o.erase = 1'b1;
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/exp_time_reg.sv
// Saturating up/down exposure time register, adjustable only while enabled.
module exp_time_reg #(
    parameter int unsigned W   = 5,
    parameter int unsigned MIN = 2,
    parameter int unsigned MAX = 30
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] exp_time
);

    localparam logic [W-1:0] MIN_V = W'(MIN);
    localparam logic [W-1:0] MAX_V = W'(MAX);
    localparam logic [W-1:0] ONE_V = W'(1);

    // Step exposure time by one per cycle held, clamped to [MIN, MAX]; both buttons cancel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_time <= MIN_V;
        end else if (en) begin
            if (inc && !dec) begin
                if (exp_time < MAX_V) begin
                    exp_time <= exp_time + ONE_V;
                end else begin
                    exp_time <= MAX_V;
                end
            end else if (dec && !inc) begin
                if (exp_time > MIN_V) begin
                    exp_time <= exp_time - ONE_V;
                end else begin
                    exp_time <= MIN_V;
                end
            end else begin
                exp_time <= exp_time;
            end
        end else begin
            exp_time <= exp_time;
        end
    end

endmodule

// File: rtl/camera_ctrl_fsm.sv
// Camera array controller: erase -> expose -> row-by-row readout with ADC strobes.
module camera_ctrl_fsm
    import camera_pkg::*;
#(
    parameter int unsigned EXP_W   = EXP_SIZE,
    parameter int unsigned EXP_LO  = EXP_MIN,
    parameter int unsigned EXP_HI  = EXP_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic init,
    input  logic exp_inc,
    input  logic exp_dec,
    output logic nre1,
    output logic nre2,
    output logic expose,
    output logic erase,
    output logic adc
);

    // Last readout cycle: two cycles (select, strobe) per row.
    localparam logic [1:0]       READ_LAST = 2'(2 * SIZE - 1);
    localparam logic [EXP_W-1:0] CNT_ONE   = EXP_W'(1);
    localparam logic [EXP_W-1:0] CNT_ZERO  = EXP_W'(0);

    cam_state_t       state_r;
    logic [EXP_W-1:0] exp_time;
    logic [EXP_W-1:0] exp_count;
    logic [1:0]       adc_read_cycle;
    cam_out_t         outs_r;
    logic             exp_en_s;

    // Exposure time is adjustable only between frames; init takes priority on its edge.
    assign exp_en_s = (state_r == IDLE) && !init;

    exp_time_reg #(
        .W   (EXP_W),
        .MIN (EXP_LO),
        .MAX (EXP_HI)
    ) u_exp_time_reg (
        .clk      (clk),
        .reset    (reset),
        .en       (exp_en_s),
        .inc      (exp_inc),
        .dec      (exp_dec),
        .exp_time (exp_time)
    );

    // Frame sequencer; outputs are registered from the decode of the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            exp_count      <= CNT_ZERO;
            adc_read_cycle <= 2'd0;
            outs_r         <= decode_outputs(IDLE, 2'd0);
        end else begin
            case (state_r)
                IDLE: begin
                    adc_read_cycle <= 2'd0;
                    if (init) begin
                        state_r   <= EXPOSE;
                        exp_count <= CNT_ONE;
                        outs_r    <= decode_outputs(EXPOSE, 2'd0);
                    end else begin
                        state_r   <= IDLE;
                        exp_count <= exp_count;
                        outs_r    <= decode_outputs(IDLE, 2'd0);
                    end
                end
                EXPOSE: begin
                    exp_count <= exp_count + CNT_ONE;
                    if (exp_count == exp_time) begin
                        state_r        <= READ;
                        adc_read_cycle <= 2'd0;
                        outs_r         <= decode_outputs(READ, 2'd0);
                    end else begin
                        state_r        <= EXPOSE;
                        adc_read_cycle <= adc_read_cycle;
                        outs_r         <= decode_outputs(EXPOSE, 2'd0);
                    end
                end
                READ: begin
                    exp_count <= exp_count;
                    if (adc_read_cycle == READ_LAST) begin
                        state_r        <= IDLE;
                        adc_read_cycle <= 2'd0;
                        outs_r         <= decode_outputs(IDLE, 2'd0);
                    end else begin
                        state_r        <= READ;
                        adc_read_cycle <= adc_read_cycle + 2'd1;
                        outs_r         <= decode_outputs(READ, adc_read_cycle + 2'd1);
                    end
                end
                default: begin
                    state_r        <= IDLE;
                    exp_count      <= CNT_ZERO;
                    adc_read_cycle <= 2'd0;
                    outs_r         <= decode_outputs(IDLE, 2'd0);
                end
            endcase
        end
    end

    assign erase  = outs_r.erase;
    assign expose = outs_r.expose;
    assign nre1   = outs_r.nre1;
    assign nre2   = outs_r.nre2;
    assign adc    = outs_r.adc;

endmodule

// File: tb/tb_camera_ctrl_fsm.sv
// Directed self-checking bench for camera_ctrl_fsm.
module tb_camera_ctrl_fsm;

    logic clk;
    logic reset;
    logic init;
    logic exp_inc;
    logic exp_dec;
    logic nre1;
    logic nre2;
    logic expose;
    logic erase;
    logic adc;

    int checks_r;
    int errors_r;

    camera_ctrl_fsm dut (
        .clk     (clk),
        .reset   (reset),
        .init    (init),
        .exp_inc (exp_inc),
        .exp_dec (exp_dec),
        .nre1    (nre1),
        .nre2    (nre2),
        .expose  (expose),
        .erase   (erase),
        .adc     (adc)
    );

    // 10 time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks_r = checks_r + 1;
        if (obs !== expv) begin
            errors_r = errors_r + 1;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected {erase, expose, nre1, nre2, adc} for cycle i after an init edge with exposure t.
    function automatic logic [4:0] exp_vec(input int i, input int t);
        if (i < t)           return 5'b01110;
        else if (i == t)     return 5'b00010;
        else if (i == t + 1) return 5'b00011;
        else if (i == t + 2) return 5'b00100;
        else if (i == t + 3) return 5'b00101;
        else                 return 5'b10110;
    endfunction

    // Hold one button pair for n rising edges, then release.
    task automatic hold_buttons(input logic inc, input logic dec, input int n);
        @(negedge clk);
        exp_inc = inc;
        exp_dec = dec;
        repeat (n) @(posedge clk);
        @(negedge clk);
        exp_inc = 1'b0;
        exp_dec = 1'b0;
    endtask

    // Run one frame of exposure t, checking every cycle; optionally toggle inputs mid-frame.
    task automatic run_frame(input int t, input bit toggle, input string tag);
        @(negedge clk);
        init = 1'b1;
        for (int i = 0; i <= t + 4; i++) begin
            @(negedge clk);
            check_val($sformatf("%s_c%0d", tag, i), {27'd0, erase, expose, nre1, nre2, adc},
                      {27'd0, exp_vec(i, t)});
            if (toggle && i <= t + 1) begin
                exp_inc = i[0];
                exp_dec = i[1];
                init    = i[2];
            end else begin
                exp_inc = 1'b0;
                exp_dec = 1'b0;
                init    = 1'b0;
            end
        end
    endtask

    initial begin
        checks_r = 0;
        errors_r = 0;
        reset    = 1'b1;
        init     = 1'b0;
        exp_inc  = 1'b0;
        exp_dec  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check_val("rst_exp_time", {27'd0, dut.exp_time}, 32'd2);
        check_val("rst_outs", {27'd0, erase, expose, nre1, nre2, adc}, {27'd0, 5'b10110});

        // Exposure adjustment and saturation
        hold_buttons(1'b1, 1'b0, 10);
        check_val("inc10", {27'd0, dut.exp_time}, 32'd12);
        hold_buttons(1'b1, 1'b0, 30);
        check_val("inc_sat", {27'd0, dut.exp_time}, 32'd30);
        hold_buttons(1'b0, 1'b1, 40);
        check_val("dec_sat", {27'd0, dut.exp_time}, 32'd2);
        hold_buttons(1'b1, 1'b0, 10);
        check_val("inc_back", {27'd0, dut.exp_time}, 32'd12);
        hold_buttons(1'b1, 1'b1, 5);
        check_val("both_hold", {27'd0, dut.exp_time}, 32'd12);
        check_val("idle_outs", {27'd0, erase, expose, nre1, nre2, adc}, {27'd0, 5'b10110});

        // Clean frame with exposure 12
        run_frame(12, 1'b0, "frame12");
        check_val("frame12_exp_time", {27'd0, dut.exp_time}, 32'd12);

        // Frame with buttons toggling throughout: no restart, exposure frozen
        run_frame(12, 1'b1, "frame_tog");
        check_val("tog_exp_time", {27'd0, dut.exp_time}, 32'd12);

        // init held across the return to IDLE starts the next frame
        @(negedge clk);
        init = 1'b1;
        repeat (12 + 4) @(negedge clk);
        check_val("held_last_read", {27'd0, erase, expose, nre1, nre2, adc}, {27'd0, 5'b00101});
        @(negedge clk);
        check_val("held_idle", {27'd0, erase, expose, nre1, nre2, adc}, {27'd0, 5'b10110});
        @(negedge clk);
        init = 1'b0;
        check_val("held_restart", {27'd0, erase, expose, nre1, nre2, adc}, {27'd0, 5'b01110});

        // Asynchronous reset mid-exposure
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_val("async_rst_outs", {27'd0, erase, expose, nre1, nre2, adc}, {27'd0, 5'b10110});
        check_val("async_rst_exp_time", {27'd0, dut.exp_time}, 32'd2);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("post_rst_idle", {27'd0, erase, expose, nre1, nre2, adc}, {27'd0, 5'b10110});

        // Minimum exposure frame
        run_frame(2, 1'b0, "frame2");

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
